// File: rtl/xm23_fetch_unit.sv
// XM23 instruction fetch sequencer: reads R7, drives MAR/CTRL, latches MDR into IR,
// writes PC+2 back and hands the instruction to the decoder over a valid/ack handshake.
module xm23_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [15:0] pc_in,
  output logic [15:0] pc_out,
  output logic        pc_we,
  output logic [15:0] mar_out,
  output logic [2:0]  ctrl_out,
  input  logic        mem_rdy,
  input  logic [15:0] mdr_in,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ack,
  input  logic        run_mode,
  input  logic        step,
  input  logic        sleep,
  input  logic [15:0] bkpnt,
  input  logic        bkpnt_en,
  output logic        bkpnt_hit,
  output logic        fault,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshake: ir_valid rises with a new ir_out and holds it stable; the decoder
  // raises ir_ack while ir_valid is high and ir_valid drops on the following cycle.
  // ir_ack seen while ir_valid is low has no effect.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_READ  = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [2:0] CTRL_IDLE = 3'b000;
  localparam logic [2:0] CTRL_READ = 3'b001;

  state_t state;
  state_t state_nxt;
  logic   step_q;
  logic   skip_bp;
  logic   step_edge;
  logic   go;
  logic   bp_match;
  logic   busy_nxt;

  // The PC lives in R7, so RESET_PC only documents where the first fetch lands;
  // an odd value simply faults on that fetch.
  if (RESET_PC[0]) begin : g_reset_pc_odd
  end

  assign step_edge = step & ~step_q;
  assign go        = (run_mode & ~sleep) | (~run_mode & ~sleep & step_edge);
  assign bp_match  = bkpnt_en & (pc_in == bkpnt);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go && bp_match && !skip_bp) begin
          state_nxt = S_HALT;
        end else if (go) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (pc_in[0]) begin
          state_nxt = S_FAULT;
        end else begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (mem_rdy) begin
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nxt = S_HOLD;
      end
      // pc_in already holds PC+2 here, so the breakpoint test sees the next fetch address.
      S_HOLD: begin
        if (ir_ack) begin
          if (run_mode && !sleep && !bp_match) begin
            state_nxt = S_ADDR;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_HALT: begin
        if (step_edge || !bkpnt_en) begin
          state_nxt = S_ADDR;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_nxt = 1'b0;
    case (state_nxt)
      S_ADDR, S_READ, S_LATCH, S_HOLD: busy_nxt = 1'b1;
      default:                         busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      step_q    <= 1'b0;
      skip_bp   <= 1'b0;
      ctrl_out  <= CTRL_IDLE;
      mar_out   <= 16'h0000;
      ir_out    <= 16'h0000;
      pc_out    <= 16'h0000;
      pc_we     <= 1'b0;
      ir_valid  <= 1'b0;
      bkpnt_hit <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_q   <= step;
      busy     <= busy_nxt;
      ctrl_out <= (state_nxt == S_READ) ? CTRL_READ : CTRL_IDLE;
      pc_we    <= 1'b0;

      if (state == S_ADDR) begin
        mar_out <= pc_in;
      end

      if (state_nxt == S_FAULT) begin
        fault <= 1'b1;
      end

      // PC write-back is issued on entry to LATCH so it leads ir_valid by one cycle.
      if (state == S_READ && mem_rdy) begin
        pc_out <= pc_in + 16'd2;
        pc_we  <= 1'b1;
      end

      if (state == S_LATCH) begin
        ir_out   <= mdr_in;
        ir_valid <= 1'b1;
        skip_bp  <= 1'b0;
      end else if (state == S_HOLD && ir_ack) begin
        ir_valid <= 1'b0;
      end

      if (state == S_IDLE && state_nxt == S_HALT) begin
        bkpnt_hit <= 1'b1;
      end

      // Leaving HALT lets the breakpoint instruction itself be fetched exactly once.
      if (state == S_HALT && state_nxt == S_ADDR) begin
        bkpnt_hit <= 1'b0;
        skip_bp   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/xm23_fetch_unit.md
# xm23_fetch_unit

Instruction fetch sequencer for the XM23 CPU. Reads the PC (R7) from the register file, drives MAR and the memory control register, waits for the word read, latches MDR into the instruction register, and writes PC+2 back. It then presents the instruction to `instruction_decoder` with a valid/ack handshake. It also enforces step/continuous execution, the PSW sleep bit and the single hardware breakpoint.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value assumed after reset; informational only, no internal PC is held.

Ports:
- `Clock` in 1: system clock, all state on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `pc_in` in 16: current R7 contents.
- `pc_out` out 16: value to write to R7.
- `pc_we` out 1: R7 write strobe, one cycle.
- `mar_out` out 16: memory address register value.
- `ctrl_out` out 3: memory control `{byte, write, enable}`. Fetch only ever drives 3'b000 or 3'b001.
- `mem_rdy` in 1: memory read data valid on `mdr_in`.
- `mdr_in` in 16: memory data register contents.
- `ir_out` out 16: fetched instruction.
- `ir_valid` out 1: `ir_out` holds an unconsumed instruction.
- `ir_ack` in 1: decoder/execute consumed `ir_out`.
- `run_mode` in 1: 1 = continuous, 0 = step (SW16).
- `step` in 1: step request level; acted on at its rising edge.
- `sleep` in 1: PSW SLP bit (psw[3]).
- `bkpnt` in 16: breakpoint address.
- `bkpnt_en` in 1: breakpoint armed.
- `bkpnt_hit` out 1: halted on breakpoint.
- `fault` out 1: odd-PC fetch fault.
- `busy` out 1: state is not IDLE, HALT or FAULT.

## Operation
States: IDLE, ADDR, READ, LATCH, HOLD, HALT, FAULT.

**Step edge detect**
- `step_edge` = `step & ~step_q`.
- `step_q` is a registered copy of `step`.

**Start condition** in IDLE: `go` = (`run_mode` & ~`sleep`) | (~`run_mode` & ~`sleep` & `step_edge`).

**IDLE**
- If `go` and `bkpnt_en` and `pc_in`==`bkpnt` and ~`skip_bp` → HALT, `bkpnt_hit`=1.
- Else if `go` → ADDR.

**ADDR**
- `mar_out`<=`pc_in`, `ctrl_out`=3'b000.
- If `pc_in[0]`=1 → FAULT, `fault`=1, no memory access.
- Else → READ.

**READ**
- `ctrl_out`=3'b001, read word, enable high.
- Held until `mem_rdy`=1, then → LATCH.
- `ctrl_out` returns to 3'b000 on leaving READ.

**LATCH**
- `ir_out`<=`mdr_in`.
- `pc_out`=`pc_in`+2 (16-bit, wraps 16'hFFFE→16'h0000), `pc_we`=1 for this cycle only.
- Clears `skip_bp`. → HOLD.

**HOLD**
- `ir_valid`=1.
- On `ir_ack`=1: `ir_valid` drops next cycle.
- Next state is ADDR if `run_mode` & ~`sleep` & ~(`bkpnt_en` & `pc_in`==`bkpnt`); otherwise IDLE.
- Breakpoint check in HOLD uses the updated `pc_in`.

**HALT**
- `bkpnt_hit`=1.
- `step_edge` or `bkpnt_en`=0 → set `skip_bp`, clear `bkpnt_hit`, → ADDR. This fetches the breakpoint instruction exactly once.

**FAULT**
- `fault`=1, sticky. Only `Reset_n` exits.

**General**
- `sleep` rising mid-fetch does not abort; the in-flight fetch completes through HOLD, then returns to IDLE.
- `run_mode` change mid-fetch takes effect at the next HOLD exit.
- `ir_ack` outside HOLD is ignored.

## Timing
**Reset values**: state IDLE; `ctrl_out`=0, `mar_out`=0, `ir_out`=0, `pc_out`=0, `pc_we`=0, `ir_valid`=0, `bkpnt_hit`=0, `fault`=0, `busy`=0, `skip_bp`=0, `step_q`=0.
- Reset asserted mid-READ drops `enable` asynchronously; no partial IR update.

**Latency**: `go` sampled at edge 0 gives ADDR during cycle 1, READ during cycle 2, `mem_rdy` sampled at the end of cycle 2 (zero wait), LATCH during cycle 3, `ir_valid` high from cycle 4.
- Each wait state extends READ by one cycle.
- Continuous back-to-back: 4 cycles per instruction with immediate ack and zero wait.

**Handshake**
- `ir_out` stable while `ir_valid`=1.
- `pc_we` never coincides with `ir_valid` rising; it leads by one cycle.

**Outputs**: all outputs registered; no combinational input→output paths.

## Test plan
- Reset, `run_mode`=1, `pc_in`=16'h0100, mem word 16'h4C8A, `mem_rdy` asserted 1 cycle after enable, `ir_ack` immediate → `ctrl_out` 3'b001 for one cycle; `pc_we` with `pc_out`=16'h0102; `ir_out`=16'h4C8A; `ir_valid` 1 cycle; next ADDR follows.
- `run_mode`=0, three `step` pulses → exactly three fetches (PC 0x0100→0x0106); holding `step` high produces no extra fetches.
- `bkpnt`=16'h0104, `bkpnt_en`=1, continuous from 0x0100 → fetches at 0x0100 and 0x0102, then HALT with `bkpnt_hit`=1 and no enable. One `step` pulse → fetches 0x0104 only; `run_mode`=1 then resumes.
- `pc_in`=16'h0201 → `fault`=1 after ADDR; `ctrl_out` never 3'b001; fault persists until `Reset_n` low.
- `sleep` raised during READ with 3 wait states → fetch completes, `ir_out` is valid, then IDLE with no new fetch. `sleep` cleared → fetching resumes.
- `pc_in`=16'hFFFE → `pc_out`=16'h0000. Separately, `Reset_n` pulsed low mid-READ → `ctrl_out`=0 immediately; all outputs at reset values.
